// File: rtl/ca_rule_engine.sv
// One-dimensional binary cellular automaton: an 8-bit rule table applied to a WIDTH-cell row for n_steps generations.
// Optional feature: define CA_WRAP_EN for a toroidal ring; otherwise the cells beyond both ends read as 0.
module ca_rule_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rule_wr,
  input  logic [7:0]       rule_in,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [CNT_W-1:0] n_steps,
  output logic [WIDTH-1:0] cells,
  output logic [CNT_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       rule_q;
  logic [CNT_W-1:0] n_lat;
  logic [WIDTH-1:0] next_gen;
  logic [WIDTH+1:0] padded;
  logic [CNT_W-1:0] gen_inc;
  logic             gen_same;
  logic             run_end;
  logic             start_ok;

  // Row extended by one neighbour at each end so every cell sees a uniform 3-bit window.
`ifdef CA_WRAP_EN
  assign padded = {cells[0], cells, cells[WIDTH-1]};
`else
  assign padded = {1'b0, cells, 1'b0};
`endif

  // Window for cell i is {c[i+1], c[i], c[i-1]} = padded[i+2:i].
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign next_gen[i] = rule_q[padded[i+2 -: 3]];
  end

  assign gen_same = (next_gen == cells);
  assign gen_inc  = (gen_count == {CNT_W{1'b1}}) ? gen_count
                                                 : gen_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign run_end  = (gen_inc == n_lat) || gen_same;
  assign start_ok = (state == IDLE) && start && !load;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_ok) state_nx = (n_steps == '0) ? DONE : RUN;
      RUN:  if (run_end) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Rule, cells and counters only move in IDLE (host writes) or RUN (stepping).
  always_ff @(posedge clk) begin
    if (reset) begin
      rule_q    <= 8'hCC;
      cells     <= '0;
      gen_count <= '0;
      n_lat     <= '0;
      stable    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rule_wr) rule_q <= rule_in;
          if (load) begin
            cells     <= seed;
            gen_count <= '0;
            stable    <= 1'b0;
          end else if (start) begin
            n_lat     <= n_steps;
            gen_count <= '0;
          end
        end
        RUN: begin
          cells     <= next_gen;
          gen_count <= gen_inc;
          stable    <= gen_same;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule
